rect_fill_engine: RTL and testbench



---
 rtl/gpu_pkg.sv | 24 ++
 rtl/rect_clip.sv | 37 +++
 rtl/rect_fill_engine.sv | 119 +++++++++++
 tb/tb_rect_fill_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - framebuffer geometry, fill state and fill command types
package gpu_pkg;

  localparam int FB_WIDTH  = 512;
  localparam int FB_HEIGHT = 256;
  localparam int FB_XW     = 9;
  localparam int FB_YW     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  typedef struct packed {
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] x2;
    logic [15:0] y2;
    logic        value;
  } fill_cmd_t;

endpackage

// File: rtl/rect_clip.sv
// rtl/rect_clip.sv - sorts rectangle corners, clips them to the framebuffer, flags empty fills
module rect_clip
  import gpu_pkg::*;
#(
  parameter int FB_XW = gpu_pkg::FB_XW,
  parameter int FB_YW = gpu_pkg::FB_YW
) (
  input  logic [15:0]      x1,
  input  logic [15:0]      y1,
  input  logic [15:0]      x2,
  input  logic [15:0]      y2,
  output logic [FB_XW-1:0] xmin,
  output logic [FB_XW-1:0] xmax,
  output logic [FB_YW-1:0] ymin,
  output logic [FB_YW-1:0] ymax,
  output logic             empty
);

  localparam logic [15:0] X_LIM = 16'((1 << FB_XW) - 1);
  localparam logic [15:0] Y_LIM = 16'((1 << FB_YW) - 1);

  logic [15:0] xlo, xhi, ylo, yhi;

  // All comparisons stay 16 bits wide so off-screen corners never alias on-screen.
  always_comb begin
    xlo   = (x1 < x2) ? x1 : x2;
    xhi   = (x1 < x2) ? x2 : x1;
    ylo   = (y1 < y2) ? y1 : y2;
    yhi   = (y1 < y2) ? y2 : y1;
    empty = (xlo > X_LIM) || (ylo > Y_LIM);
    xmin  = xlo[FB_XW-1:0];
    ymin  = ylo[FB_YW-1:0];
    xmax  = (xhi > X_LIM) ? '1 : xhi[FB_XW-1:0];
    ymax  = (yhi > Y_LIM) ? '1 : yhi[FB_YW-1:0];
  end

endmodule

// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - rectangle fill sequencer driving GPU_RAM port 2; RECT_FILL_BLANK_GATE_EN gates writes to blanking
module rect_fill_engine
  import gpu_pkg::*;
#(
  parameter int FB_XW = gpu_pkg::FB_XW,
  parameter int FB_YW = gpu_pkg::FB_YW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_x1,
  input  logic [15:0]      cmd_y1,
  input  logic [15:0]      cmd_x2,
  input  logic [15:0]      cmd_y2,
  input  logic             cmd_value,
  input  logic             write_allow,
  output logic [FB_XW-1:0] ram_x,
  output logic [FB_YW-1:0] ram_y,
  output logic             ram_we,
  output logic             ram_wdata,
  output logic             busy,
  output logic             done
);

  fill_state_t      state, state_nxt;
  fill_cmd_t        cmd_q;
  logic [FB_XW-1:0] xmin_c, xmax_c, xmin_q, xmax_q, cx;
  logic [FB_YW-1:0] ymin_c, ymax_c, ymax_q, cy;
  logic             empty_c;
  logic             wr_gate;
  logic             last_px;

`ifdef RECT_FILL_BLANK_GATE_EN
  assign wr_gate = write_allow;
`else
  logic unused_write_allow;
  assign unused_write_allow = write_allow;
  assign wr_gate = 1'b1;
`endif

  rect_clip #(.FB_XW(FB_XW), .FB_YW(FB_YW)) u_clip (
    .x1    (cmd_q.x1),
    .y1    (cmd_q.y1),
    .x2    (cmd_q.x2),
    .y2    (cmd_q.y2),
    .xmin  (xmin_c),
    .xmax  (xmax_c),
    .ymin  (ymin_c),
    .ymax  (ymax_c),
    .empty (empty_c)
  );

  assign last_px   = (cx == xmax_q) && (cy == ymax_q);
  assign ram_x     = cx;
  assign ram_y     = cy;
  assign ram_wdata = cmd_q.value;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    ram_we    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP:   state_nxt = empty_c ? DONE : WRITE;
      WRITE: begin
        ram_we = wr_gate;
        if (wr_gate && last_px) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters double as the registered RAM address, so they only move after a real write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q  <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      cx     <= '0;
      cy     <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        cmd_q <= '{x1: cmd_x1, y1: cmd_y1, x2: cmd_x2, y2: cmd_y2, value: cmd_value};
      end
      if (state == SETUP) begin
        xmin_q <= xmin_c;
        xmax_q <= xmax_c;
        ymax_q <= ymax_c;
        cx     <= xmin_c;
        cy     <= ymin_c;
      end
      if (ram_we && !last_px) begin
        if (cx == xmax_q) begin
          cx <= xmin_q;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb/tb_rect_fill_engine.sv - scoreboard bench for rect_fill_engine
module tb_rect_fill_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_x1, cmd_y1, cmd_x2, cmd_y2;
  logic        cmd_value;
  logic        write_allow;
  logic [8:0]  ram_x;
  logic [7:0]  ram_y;
  logic        ram_we;
  logic        ram_wdata;
  logic        busy;
  logic        done;

  rect_fill_engine dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x1      (cmd_x1),
    .cmd_y1      (cmd_y1),
    .cmd_x2      (cmd_x2),
    .cmd_y2      (cmd_y2),
    .cmd_value   (cmd_value),
    .write_allow (write_allow),
    .ram_x       (ram_x),
    .ram_y       (ram_y),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ncyc = 0;
  int n_wr = 0;
  int done_cnt = 0;
  int first_we = -1;
  int last_we = 0;
  int done_cyc = 0;
  int acc = 0;
  int w0 = 0;
  int d0 = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    logic [17:0] e;
    if (reset) begin
      if (ram_we) begin
        n_wr++;
        if (first_we < 0) first_we = ncyc;
        last_we = ncyc;
        if (exp_q.size() == 0) begin
          check("spurious_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_pixel", {14'd0, ram_x, ram_y, ram_wdata}, {14'd0, e});
        end
`ifdef RECT_FILL_BLANK_GATE_EN
        check("wr_in_blank", {31'd0, write_allow}, 32'd1);
`endif
      end
      if (done) begin
        done_cnt++;
        done_cyc = ncyc;
      end
    end
  end

  task automatic push_px(input int x, input int y, input bit v);
    exp_q.push_back({9'(x), 8'(y), v});
  endtask

  task automatic push_rect(input int x1, input int y1, input int x2, input int y2, input bit v);
    int xl, xh, yl, yh;
    xl = (x1 < x2) ? x1 : x2;
    xh = (x1 < x2) ? x2 : x1;
    yl = (y1 < y2) ? y1 : y2;
    yh = (y1 < y2) ? y2 : y1;
    if (xl > 511 || yl > 255) return;
    if (xh > 511) xh = 511;
    if (yh > 255) yh = 255;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        push_px(x, y, v);
  endtask

  task automatic start_cmd(input int x1, input int y1, input int x2, input int y2,
                           input bit v, input bit hold);
    bit ok;
    @(posedge clk); #1;
    cmd_x1 = 16'(x1); cmd_y1 = 16'(y1); cmd_x2 = 16'(x2); cmd_y2 = 16'(y2);
    cmd_value = v;
    cmd_valid = 1'b1;
    w0 = n_wr; d0 = done_cnt; first_we = -1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = ncyc; ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = hold;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (done_cnt == d0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic post_fill(input int exp_n, input bit chk_first, input bit empty);
    check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    check("n_writes", n_wr - w0, exp_n);
    check("done_once", done_cnt - d0, 32'd1);
    if (empty) begin
      check("done_lat_empty", done_cyc - acc, 32'd2);
    end else begin
      check("done_after_last", done_cyc - last_we, 32'd1);
      if (chk_first) check("first_write_lat", first_we - acc, 32'd2);
    end
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int a1, a2, viol, wr_snap, dn_snap, n;
    bit ok;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_x1 = '0; cmd_y1 = '0; cmd_x2 = '0; cmd_y2 = '0;
    cmd_value = 1'b0;
    write_allow = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_x", {23'd0, ram_x}, 32'd0);
    check("rst_ram_y", {24'd0, ram_y}, 32'd0);
    check("rst_ram_wdata", {31'd0, ram_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // basic fill, expected raster order written out by hand
    push_px(2, 3, 1); push_px(3, 3, 1); push_px(4, 3, 1);
    push_px(2, 4, 1); push_px(3, 4, 1); push_px(4, 4, 1);
    start_cmd(2, 3, 4, 4, 1'b1, 1'b0);
    wait_done(100);
    post_fill(6, 1'b1, 1'b0);

    // swapped and clipped corners
    push_px(510, 254, 0); push_px(511, 254, 0);
    push_px(510, 255, 0); push_px(511, 255, 0);
    start_cmd(600, 300, 510, 254, 1'b0, 1'b0);
    wait_done(100);
    post_fill(4, 1'b1, 1'b0);

    // fully off-screen
    start_cmd(520, 10, 700, 20, 1'b1, 1'b0);
    wait_done(100);
    post_fill(0, 1'b0, 1'b1);

    // 1x1 fills back to back with cmd_valid held
    push_px(5, 5, 1); push_px(5, 5, 1);
    @(posedge clk); #1;
    cmd_x1 = 16'd5; cmd_y1 = 16'd5; cmd_x2 = 16'd5; cmd_y2 = 16'd5;
    cmd_value = 1'b1; cmd_valid = 1'b1;
    w0 = n_wr; d0 = done_cnt;
    @(negedge clk);
    a1 = ncyc;
    check("1x1_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    ok = 1'b0; a2 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin a2 = ncyc; ok = 1'b1; break; end
    end
    check("1x1_reaccept_found", {31'd0, ok}, 32'd1);
    check("1x1_accept_to_accept", a2 - a1, 32'd4);
    check("1x1_accept_to_done", done_cyc - a1, 32'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    d0 = done_cnt;
    wait_done(100);
    check("1x1_writes", n_wr - w0, 32'd2);
    check("1x1_sb_drained", exp_q.size(), 32'd0);

`ifdef RECT_FILL_BLANK_GATE_EN
    // gated fill: 3 cycles of blanking, 5 of active video
    push_rect(0, 0, 9, 0, 1'b1);
    start_cmd(0, 0, 9, 0, 1'b1, 1'b0);
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk); #1;
      write_allow = ((n % 8) < 3);
      n++;
    end
    if (done_cnt == d0) check("gated_done_timeout", 32'd0, 32'd1);
    post_fill(10, 1'b0, 1'b0);
    write_allow = 1'b1;
`else
    // write_allow ignored: back-to-back writes
    write_allow = 1'b0;
    push_rect(0, 10, 7, 11, 1'b1);
    start_cmd(0, 10, 7, 11, 1'b1, 1'b0);
    wait_done(100);
    post_fill(16, 1'b1, 1'b0);
    check("b2b_span", last_we - first_we, 32'd15);
    write_allow = 1'b1;
`endif

    // cmd_valid held while busy, then a large fill interrupted by reset
    push_rect(1, 1, 2, 1, 1'b1);
    start_cmd(1, 1, 2, 1, 1'b1, 1'b1);
    viol = 0; n = 0;
    while (done_cnt == d0 && n < 100) begin
      if (busy && cmd_ready) viol++;
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == d0) check("hold_done_timeout", 32'd0, 32'd1);
    post_fill(2, 1'b1, 1'b0);
    check("no_accept_while_busy", viol, 32'd0);
    cmd_x1 = 16'd0; cmd_y1 = 16'd0; cmd_x2 = 16'd511; cmd_y2 = 16'd255;
    push_rect(0, 0, 511, 255, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.delete();
    wr_snap = n_wr; dn_snap = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_writes", n_wr - wr_snap, 32'd0);
    check("post_rst_no_done", done_cnt - dn_snap, 32'd0);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
